// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: shares one handshaked memory port between instruction fetch and load/store,
// stepping each instruction through FETCH -> EXEC -> (DATA) -> COMMIT and gating the datapath with cpu_advance.
// Latency: 3 cycles per non-memory instruction and 4 per load/store with zero-wait memory; each wait cycle adds one.
// Backpressure: a request (mem_req/mem_we/mem_addr/mem_wdata) is held until mem_ack; TIMEOUT waiting cycles -> err[1], HALT.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc / inst           fetch address from datapath / latched instruction word
//   halted, dmem_*      EXEC-cycle requests from control/datapath (halt, load, store, address, store data)
//   dmem_rdata          latched load data, valid in COMMIT
//   cpu_advance         one-cycle commit pulse (PC update, register write enable)
//   mem_*               handshaked memory port (req/we/addr/wdata out, ack/rdata in)
//   halt_done, err      HALT state flag; sticky errors {timeout, rd&wr conflict}
//   inst_count          retired-instruction counter, wraps silently
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  input  logic              halted,
  input  logic              dmem_rd,
  input  logic              dmem_wr,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              cpu_advance,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halt_done,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  inst_count
);

  // The wait counter holds the number of already-elapsed waiting cycles, so the
  // timeout fires in the TIMEOUT-th waiting cycle and the request is up for
  // exactly TIMEOUT cycles.
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_DATA, S_COMMIT, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [31:0] wait_cnt;
  logic        waiting;
  logic        timeout_hit;
  logic        data_go;

  assign waiting     = ((state == S_FETCH) || (state == S_DATA)) && !mem_ack;
  assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == TO_LAST);
  // A halt in EXEC takes priority over any memory operation.
  assign data_go     = (state == S_EXEC) && !halted && (dmem_rd || dmem_wr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    cpu_advance = 1'b0;
    halt_done   = 1'b0;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack)          state_nxt = S_EXEC;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_EXEC: begin
        if (halted)       state_nxt = S_HALT;
        else if (data_go) state_nxt = S_DATA;
        else              state_nxt = S_COMMIT;
      end
      S_DATA: begin
        mem_req = 1'b1;
        if (mem_ack)          state_nxt = S_COMMIT;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_COMMIT: begin
        cpu_advance = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_HALT:   halt_done = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // we_q is cleared on every fetch entry, so gating by mem_req is enough to
  // keep mem_we low outside a request.
  assign mem_we = mem_req & we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= '0;
      dmem_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_count <= '0;
      we_q       <= 1'b0;
      wait_cnt   <= '0;
      err        <= 2'b00;
    end else begin
      if (waiting)     wait_cnt <= wait_cnt + 32'd1;
      if (timeout_hit) err[1]   <= 1'b1;
      case (state)
        // Both of these enter FETCH on the next edge: capture the fetch address.
        S_IDLE, S_COMMIT: begin
          mem_addr <= pc;
          we_q     <= 1'b0;
          wait_cnt <= '0;
        end
        S_FETCH: if (mem_ack) inst <= mem_rdata;
        S_EXEC: begin
          if (data_go) begin
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_wdata;
            // Store wins when both are requested; the load is dropped.
            we_q      <= dmem_wr;
            wait_cnt  <= '0;
            if (dmem_rd && dmem_wr) err[0] <= 1'b1;
          end
        end
        S_DATA: if (mem_ack && !we_q) dmem_rdata <= mem_rdata;
        default: ;
      endcase
      if (state == S_COMMIT) inst_count <= inst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic [DW-1:0] inst;
  logic          halted, dmem_rd, dmem_wr;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          cpu_advance, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          halt_done;
  logic [1:0]    err;
  logic [CW-1:0] inst_count;

  mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .halted(halted),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .cpu_advance(cpu_advance), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .halt_done(halt_done), .err(err), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int adv_total = 0;

  always @(negedge clk) if (cpu_advance === 1'b1) adv_total++;

  // Reference model state, derived from the architectural rules.
  logic [CW-1:0] m_count;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] cur_pc;
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  // Observations recorded by the instruction driver.
  logic          obs_req, obs_unstable, obs_data, obs_halt, obs_adv, obs_fwe, obs_dwe;
  logic [AW-1:0] obs_faddr, obs_daddr;
  logic [DW-1:0] obs_dwd, obs_inst, obs_rdata;
  logic [CW-1:0] obs_cnt;
  int            obs_lat, obs_commit_cyc, obs_req_cycles;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0; halted = 1'b0; dmem_rd = 1'b0; dmem_wr = 1'b0;
    pc = cur_pc;
    repeat (2) tick();
    rst = 1'b0;
    m_count = '0;
    m_rdata = '0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 load+store, 4 halt, 5 fetch never acknowledged
  task automatic exec_instr(input int kind, input int fw, input int dw, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rword,
                            input logic [DW-1:0] iw, input logic [AW-1:0] next_pc);
    int start;
    obs_req = 0; obs_unstable = 0; obs_data = 0; obs_halt = 0; obs_adv = 0;
    obs_req_cycles = 0; obs_lat = -1; obs_commit_cyc = -1;
    for (int n = 0; n < 10 && mem_req !== 1'b1; n++) tick();
    if (mem_req !== 1'b1) return;
    obs_req = 1; obs_faddr = mem_addr; obs_fwe = mem_we; start = cyc;
    if (kind == 5) begin
      for (int n = 0; n < 50 && mem_req === 1'b1; n++) begin obs_req_cycles++; tick(); end
      return;
    end
    for (int i = 0; i < fw; i++) begin
      tick();
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== obs_faddr) obs_unstable = 1;
    end
    mem_ack = 1'b1; mem_rdata = iw;
    halted  = (kind == 4);
    dmem_rd = (kind == 1 || kind == 3);
    dmem_wr = (kind == 2 || kind == 3);
    dmem_addr = a; dmem_wdata = wd;
    tick();                                   // EXEC
    mem_ack = 1'b0; mem_rdata = $urandom; obs_inst = inst;
    pc = next_pc; cur_pc = next_pc;
    tick();
    halted = 1'b0; dmem_rd = 1'b0; dmem_wr = 1'b0; dmem_addr = $urandom; dmem_wdata = $urandom;
    if (kind == 4) begin obs_halt = halt_done; return; end
    if (mem_req === 1'b1) begin
      obs_data = 1; obs_daddr = mem_addr; obs_dwe = mem_we; obs_dwd = mem_wdata;
      for (int i = 0; i < dw; i++) begin
        tick();
        if (mem_req !== 1'b1 || mem_we !== obs_dwe || mem_addr !== obs_daddr || mem_wdata !== obs_dwd)
          obs_unstable = 1;
      end
      mem_ack = 1'b1; mem_rdata = rword;
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    obs_adv = cpu_advance; obs_lat = cyc - start; obs_rdata = dmem_rdata; obs_commit_cyc = cyc;
    tick();
    obs_cnt = inst_count;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ack = 1'b0; halted = 1'b0; dmem_rd = 1'b0; dmem_wr = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; mem_rdata = '0;
    cur_pc = 32'h0000_1000; pc = cur_pc;
    #2 rst = 1'b1;
    #1;
    cmp++; if ({mem_req, mem_we, cpu_advance, halt_done, err} !== 6'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, cpu_advance, halt_done, err}); end
    cmp++; if ({inst, dmem_rdata, mem_addr, mem_wdata, inst_count} !== '0) begin bad++;
      $display("FAIL reset_regs: inst=%h rdata=%h addr=%h wdata=%h cnt=%0d want all 0",
               inst, dmem_rdata, mem_addr, mem_wdata, inst_count); end
    repeat (2) tick();
    rst = 1'b0; m_count = '0; m_rdata = '0;
    cmp++; if (mem_req !== 1'b0) begin bad++; $display("FAIL req_at_release: got %b want 0", mem_req); end
    tick();
    cmp++; if (mem_req !== 1'b1 || mem_addr !== cur_pc) begin bad++;
      $display("FAIL first_fetch: req=%b addr=%h want 1 %h", mem_req, mem_addr, cur_pc); end
  endtask

  task automatic test_alu();
    int c [3];
    int a0;
    logic [AW-1:0] exp_pc;
    logic [DW-1:0] iw;
    a0 = adv_total;
    for (int i = 0; i < 3; i++) begin
      exp_pc = cur_pc; iw = $urandom;
      exec_instr(0, 0, 0, '0, '0, '0, iw, cur_pc + 32'd4);
      m_count = m_count + 1'b1;
      c[i] = obs_commit_cyc;
      cmp++; if (obs_faddr !== exp_pc || obs_inst !== iw) begin bad++;
        $display("FAIL alu_fetch[%0d]: addr=%h inst=%h want %h %h", i, obs_faddr, obs_inst, exp_pc, iw); end
    end
    cmp++; if (c[1] - c[0] != 3 || c[2] - c[1] != 3) begin bad++;
      $display("FAIL alu_spacing: got %0d,%0d want 3,3", c[1] - c[0], c[2] - c[1]); end
    cmp++; if (inst_count !== 4'd3 || adv_total - a0 != 3) begin bad++;
      $display("FAIL alu_count: cnt=%0d pulses=%0d want 3 3", inst_count, adv_total - a0); end
  endtask

  task automatic test_load();
    int a0;
    a0 = adv_total;
    exec_instr(1, 0, 2, 32'h40, $urandom, 32'hDEAD_BEEF, $urandom, cur_pc + 32'd4);
    m_rdata = 32'hDEAD_BEEF; m_count = m_count + 1'b1;
    cmp++; if (!obs_data || obs_daddr !== 32'h40 || obs_dwe !== 1'b0 || obs_unstable) begin bad++;
      $display("FAIL load_req: data=%b addr=%h we=%b unstable=%b want 1 40 0 0", obs_data, obs_daddr, obs_dwe, obs_unstable); end
    cmp++; if (obs_rdata !== 32'hDEAD_BEEF || !obs_adv || adv_total - a0 != 1) begin bad++;
      $display("FAIL load_commit: rdata=%h adv=%b pulses=%0d want deadbeef 1 1", obs_rdata, obs_adv, adv_total - a0); end
    cmp++; if (obs_lat != 5) begin bad++; $display("FAIL load_latency: got %0d want 5", obs_lat); end
  endtask

  task automatic test_store();
    exec_instr(2, 1, 3, 32'h80, 32'h1234_5678, $urandom, $urandom, cur_pc + 32'd4);
    m_count = m_count + 1'b1;
    cmp++; if (!obs_data || obs_dwe !== 1'b1 || obs_daddr !== 32'h80 || obs_dwd !== 32'h1234_5678 || obs_unstable) begin bad++;
      $display("FAIL store_req: we=%b addr=%h wdata=%h unstable=%b want 1 80 12345678 0", obs_dwe, obs_daddr, obs_dwd, obs_unstable); end
    cmp++; if (obs_rdata !== m_rdata || !obs_adv || obs_lat != 7) begin bad++;
      $display("FAIL store_commit: rdata=%h adv=%b lat=%0d want %h 1 7", obs_rdata, obs_adv, obs_lat, m_rdata); end
  endtask

  task automatic test_random();
    int kind, fw, dw, exp_lat;
    logic [AW-1:0] a, exp_pc;
    logic [DW-1:0] wd, rw;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2); fw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4; wd = $urandom; exp_pc = cur_pc;
      rw = mem_model.exists(a) ? mem_model[a] : $urandom;
      exec_instr(kind, fw, dw, a, wd, rw, $urandom, 32'($urandom_range(0, 1023)) * 4);
      if (kind == 1) m_rdata = rw;
      if (kind != 0) mem_model[a] = (kind == 2) ? wd : rw;
      m_count = m_count + 1'b1;
      exp_lat = fw + 2 + ((kind != 0) ? dw + 1 : 0);
      cmp++; if (obs_faddr !== exp_pc || obs_fwe !== 1'b0 || obs_unstable) begin bad++;
        $display("FAIL rnd_fetch[%0d]: addr=%h we=%b unstable=%b want %h 0 0", i, obs_faddr, obs_fwe, obs_unstable, exp_pc); end
      cmp++; if (obs_data !== (kind != 0)) begin bad++;
        $display("FAIL rnd_data_phase[%0d]: got %b want %b", i, obs_data, kind != 0); end
      if (kind != 0) begin
        cmp++; if (obs_daddr !== a || obs_dwe !== (kind == 2) || (kind == 2 && obs_dwd !== wd)) begin bad++;
          $display("FAIL rnd_data_req[%0d]: addr=%h we=%b wdata=%h want %h %b %h", i, obs_daddr, obs_dwe, obs_dwd, a, kind == 2, wd); end
      end
      cmp++; if (obs_lat != exp_lat || obs_adv !== 1'b1) begin bad++;
        $display("FAIL rnd_commit[%0d]: lat=%0d adv=%b want %0d 1", i, obs_lat, obs_adv, exp_lat); end
      cmp++; if (obs_rdata !== m_rdata || obs_cnt !== m_count) begin bad++;
        $display("FAIL rnd_state[%0d]: rdata=%h cnt=%0d want %h %0d", i, obs_rdata, obs_cnt, m_rdata, m_count); end
    end
  endtask

  task automatic test_both();
    exec_instr(3, 0, 0, 32'h1C0, 32'hA5A5_0F0F, 32'hFFFF_0000, $urandom, cur_pc + 32'd4);
    m_count = m_count + 1'b1;
    cmp++; if (!obs_data || obs_dwe !== 1'b1 || obs_daddr !== 32'h1C0 || obs_dwd !== 32'hA5A5_0F0F) begin bad++;
      $display("FAIL both_write: we=%b addr=%h wdata=%h want 1 1c0 a5a50f0f", obs_dwe, obs_daddr, obs_dwd); end
    cmp++; if (err !== 2'b01 || obs_rdata !== m_rdata || obs_cnt !== m_count) begin bad++;
      $display("FAIL both_state: err=%b rdata=%h cnt=%0d want 01 %h %0d", err, obs_rdata, obs_cnt, m_rdata, m_count); end
  endtask

  task automatic test_halt();
    int a0, reqs;
    exec_instr(4, 0, 0, '0, '0, '0, $urandom, cur_pc + 32'd4);
    cmp++; if (obs_halt !== 1'b1) begin bad++; $display("FAIL halt_enter: got %b want 1", obs_halt); end
    a0 = adv_total; reqs = 0;
    for (int i = 0; i < 100; i++) begin
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      tick();
      if (mem_req !== 1'b0) reqs++;
    end
    mem_ack = 1'b0;
    cmp++; if (reqs != 0 || adv_total - a0 != 0 || halt_done !== 1'b1 || inst_count !== m_count) begin bad++;
      $display("FAIL halt_hold: reqs=%0d pulses=%0d halt=%b cnt=%0d want 0 0 1 %0d", reqs, adv_total - a0, halt_done, inst_count, m_count); end
  endtask

  task automatic test_reset_mid();
    cur_pc = 32'h0000_0200;
    do_reset();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; dmem_rd = 1'b1; dmem_addr = 32'h0000_0300;
    tick();
    mem_ack = 1'b0;
    tick();
    dmem_rd = 1'b0;
    tick();
    cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++;
      $display("FAIL mid_data_wait: req=%b addr=%h want 1 300", mem_req, mem_addr); end
    #2 rst = 1'b1;
    #1;
    cmp++; if ({mem_req, mem_we, cpu_advance, halt_done, err} !== 6'b0 || {inst, mem_addr, dmem_rdata, inst_count} !== '0) begin bad++;
      $display("FAIL mid_reset: ctrl=%b inst=%h addr=%h rdata=%h cnt=%0d want all 0",
               {mem_req, mem_we, cpu_advance, halt_done, err}, inst, mem_addr, dmem_rdata, inst_count); end
    cur_pc = 32'h0000_0ABC & ~32'h3; pc = cur_pc;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== cur_pc) begin bad++;
      $display("FAIL mid_refetch: req=%b we=%b addr=%h want 1 0 %h", mem_req, mem_we, mem_addr, cur_pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    exec_instr(5, 0, 0, '0, '0, '0, '0, cur_pc);
    cmp++; if (obs_req_cycles != TO) begin bad++;
      $display("FAIL timeout_cycles: got %0d want %0d", obs_req_cycles, TO); end
    cmp++; if (halt_done !== 1'b1 || err !== 2'b10 || mem_req !== 1'b0) begin bad++;
      $display("FAIL timeout_state: halt=%b err=%b req=%b want 1 10 0", halt_done, err, mem_req); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_random();
    test_both();
    test_halt();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
